dcache_controller: RTL and testbench

//   Direct-mapped, write-back, write-allocate L1 data cache.

---
 rtl/dcache_controller.sv | 142 ++++++++++++++
 tb/tb_dcache_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache: zero-stall hits, misses stall through
// optional write-back, refill and one RETRY cycle. `DCACHE_STATS_EN adds hit/miss counters.
module dcache_controller #(
  parameter int SETS      = 32,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int WORDS  = LINE_BITS / 32;
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_RETRY} state_t;

  state_t                    state;
  logic                      line_valid [SETS];
  logic                      line_dirty [SETS];
  logic [TAG_W-1:0]          line_tag   [SETS];
  logic [WORDS-1:0][31:0]    line_data  [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic [ADDR_W-1:0] refill_addr;
  logic              hit;
  logic              serve;
  logic              unused_addr_bits;

  assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_wsel         = cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign refill_addr      = {req_tag, req_idx, {OFF_W{1'b0}}};

  assign hit   = cpu_req_i && line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  // RETRY completes the held access exactly like an IDLE hit
  assign serve = !rst_i && hit && (state == S_IDLE || state == S_RETRY);

  assign cpu_rdata_o = serve ? line_data[req_idx][req_wsel] : 32'd0;
  assign cpu_stall_o = !rst_i && ((state == S_IDLE && cpu_req_i && !hit) ||
                                  state == S_WRITEBACK || state == S_REFILL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      for (int s = 0; s < SETS; s++) begin
        line_valid[s] <= 1'b0;
        line_dirty[s] <= 1'b0;
      end
    end else begin
      if (serve && cpu_we_i)
        line_dirty[req_idx] <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cpu_req_i && !hit) begin
            mem_req_o <= 1'b1;
            if (line_valid[req_idx] && line_dirty[req_idx]) begin
              state       <= S_WRITEBACK;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {line_tag[req_idx], req_idx, {OFF_W{1'b0}}};
              mem_wdata_o <= line_data[req_idx];
            end else begin
              state      <= S_REFILL;
              mem_we_o   <= 1'b0;
              mem_addr_o <= refill_addr;
            end
          end
        end
        S_WRITEBACK: begin
          // request stays up and moves straight on to the fetch
          if (mem_ack_i) begin
            state      <= S_REFILL;
            mem_we_o   <= 1'b0;
            mem_addr_o <= refill_addr;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            state               <= S_RETRY;
            mem_req_o           <= 1'b0;
            line_valid[req_idx] <= 1'b1;
            line_dirty[req_idx] <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies them
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_REFILL && mem_ack_i) begin
        line_data[req_idx] <= mem_rdata_i;
        line_tag[req_idx]  <= req_tag;
      end else if (serve && cpu_we_i) begin
        line_data[req_idx][req_wsel] <= cpu_wdata_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (state == S_IDLE && cpu_req_i) begin
      if (hit)
        hit_cnt_o <= hit_cnt_o + 32'd1;
      else
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural line memory answering after a set delay.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [255:0] mem [128];
  int           ack_lat;
  int           req_age;
  int           wb_cnt;
  int           rf_cnt;
  logic [31:0]  wb_addr;
  logic [31:0]  rf_addr;
  logic         saw_we;
  logic         saw_req;
  int           n_checks;
  int           n_errors;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called once per cycle at the falling edge: answers the open request after ack_lat cycles
  task automatic mem_service();
    mem_ack_i = 1'b0;
    if (mem_req_o) begin
      saw_req = 1'b1;
      if (mem_we_o) saw_we = 1'b1;
      req_age++;
      if (req_age >= ack_lat) begin
        mem_ack_i = 1'b1;
        req_age   = 0;
        if (mem_we_o) begin
          mem[mem_addr_o[11:5]] = mem_wdata_o;
          wb_cnt++;
          wb_addr = mem_addr_o;
        end else begin
          mem_rdata_i = mem[mem_addr_o[11:5]];
          rf_cnt++;
          rf_addr = mem_addr_o;
        end
      end
    end else begin
      req_age = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      mem_service();
      @(posedge clk_i);
      #1;
    end
  endtask

  // Holds one access until the cycle it completes; counts stalled cycles
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output int stalls);
    logic done;
    done        = 1'b0;
    stalls      = 0;
    rd          = '0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      mem_service();
      if (!cpu_stall_o) begin
        rd   = cpu_rdata_o;
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk_i);
      #1;
    end
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
    check({tag, "_completed"}, done, 1'b1);
  endtask

  logic [31:0]  rd;
  int           st;
  logic [255:0] line;

  initial begin
    n_checks = 0;
    n_errors = 0;
    wb_cnt = 0; rf_cnt = 0; req_age = 0; ack_lat = 10;
    wb_addr = '0; rf_addr = '0; saw_we = 1'b0; saw_req = 1'b0;
    for (int i = 0; i < 128; i++) begin
      for (int w = 0; w < 8; w++) line[w*32 +: 32] = (i << 8) + w;
      mem[i] = line;
    end
    line = mem[0];
    line[31:0] = 32'd5;
    mem[0] = line;

    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_stall", cpu_stall_o, 1'b0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_we", mem_we_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 256'd0);
    check("rst_rdata", cpu_rdata_o, 32'd0);
    check("rst_valid0", dut.line_valid[0], 1'b0);
    @(posedge clk_i);
    #1;

    // 1: cold load miss, memory answers in the 10th request cycle
    ack_lat = 10;
    access("t1", 1'b0, 32'h0000_0000, 32'd0, rd, st);
    check("t1_rdata", rd, 32'd5);
    check("t1_stalls", st, 11);
    check("t1_refills", rf_cnt, 1);
    check("t1_refill_addr", rf_addr, 32'h0);
    check("t1_writebacks", wb_cnt, 0);
    check("t1_valid0", dut.line_valid[0], 1'b1);
    check("t1_dirty0", dut.line_dirty[0], 1'b0);
    check("t1_req_dropped", mem_req_o, 1'b0);

    // 2: store then load hit, no memory traffic
    saw_req = 1'b0;
    access("t2s", 1'b1, 32'h0000_0004, 32'h2A, rd, st);
    check("t2_store_stalls", st, 0);
    access("t2l", 1'b0, 32'h0000_0004, 32'd0, rd, st);
    check("t2_load_stalls", st, 0);
    check("t2_rdata", rd, 32'h2A);
    check("t2_dirty0", dut.line_dirty[0], 1'b1);
    check("t2_no_mem_req", saw_req, 1'b0);

    // 3: conflicting load evicts dirty line 0
    ack_lat = 3;
    access("t3", 1'b0, 32'h0000_0400, 32'd0, rd, st);
    check("t3_rdata", rd, 32'h0000_2000);
    check("t3_stalls", st, 7);
    check("t3_writebacks", wb_cnt, 1);
    check("t3_wb_addr", wb_addr, 32'h0);
    line = mem[0];
    check("t3_wb_word0", line[31:0], 32'd5);
    check("t3_wb_word1", line[63:32], 32'h2A);
    check("t3_refill_addr", rf_addr, 32'h400);
    check("t3_tag0", dut.line_tag[0], 22'd1);
    check("t3_dirty0", dut.line_dirty[0], 1'b0);
`ifdef DCACHE_STATS_EN
    check("stats_hits", hit_cnt_o, 32'd2);
    check("stats_misses", miss_cnt_o, 32'd2);
`endif

    // 4: store miss to an invalid line allocates without write-back
    ack_lat = 2;
    saw_we = 1'b0;
    access("t4", 1'b1, 32'h0000_0024, 32'hDEAD_BEEF, rd, st);
    check("t4_stalls", st, 3);
    check("t4_no_wb", saw_we, 1'b0);
    check("t4_writebacks", wb_cnt, 1);
    check("t4_dirty1", dut.line_dirty[1], 1'b1);
    access("t4r1", 1'b0, 32'h0000_0024, 32'd0, rd, st);
    check("t4_word1", rd, 32'hDEAD_BEEF);
    access("t4r0", 1'b0, 32'h0000_0020, 32'd0, rd, st);
    check("t4_word0", rd, 32'h0000_0100);
    check("t4_hit_stalls", st, 0);

    // 5: reset in the middle of a refill, then a stray ack
    ack_lat = 8;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0800;
    idle(4);
    check("t5_req_open", mem_req_o, 1'b1);
    check("t5_stall_open", cpu_stall_o, 1'b1);
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("t5_req_cleared", mem_req_o, 1'b0);
    check("t5_stall_cleared", cpu_stall_o, 1'b0);
    check("t5_valid0", dut.line_valid[0], 1'b0);
    check("t5_dirty1", dut.line_dirty[1], 1'b0);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_rdata_i = {256{1'b1}};
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("t5_late_req", mem_req_o, 1'b0);
    check("t5_late_valid0", dut.line_valid[0], 1'b0);
    check("t5_late_stall", cpu_stall_o, 1'b0);
    ack_lat = 2;
    access("t5m", 1'b0, 32'h0000_0400, 32'd0, rd, st);
    check("t5_remiss_stalls", st, 3);
    check("t5_remiss_rdata", rd, 32'h0000_2000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
